// File: rtl/pipelined_adder.sv
// Pipelined SIZE-bit adder/subtractor, STAGES slices of SIZE/STAGES bits each, valid/ready handshake.
// Define PIPE_ADD_OVF_EN to add the registered signed-overflow output 'ovf'.
module pipelined_adder #(
    parameter int SIZE   = 16,
    parameter int STAGES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            cin,
    input  logic            sub,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] sum,
    output logic            carry_out
`ifdef PIPE_ADD_OVF_EN
    ,
    output logic            ovf
`endif
);

    localparam int W    = SIZE / STAGES;
    localparam int LAST = STAGES - 1;

    logic            adv;

    logic            v_q   [STAGES];
    logic [SIZE-1:0] r_q   [STAGES];
    logic [SIZE-1:0] a_q   [STAGES];
    logic [SIZE-1:0] b_q   [STAGES];
    logic            c_q   [STAGES];

    logic            v_src [STAGES];
    logic [SIZE-1:0] r_src [STAGES];
    logic [SIZE-1:0] a_src [STAGES];
    logic [SIZE-1:0] b_src [STAGES];
    logic            c_src [STAGES];

    logic [SIZE-1:0] r_nxt [STAGES];
    logic            c_nxt [STAGES];
    logic [W:0]      slice;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Stage 0 takes the ports (b and cin inverted for subtract); every later stage takes its predecessor.
    always_comb begin
        v_src[0] = in_valid;
        r_src[0] = '0;
        a_src[0] = a;
        b_src[0] = sub ? ~b : b;
        c_src[0] = sub ? ~cin : cin;
        for (int k = 1; k < STAGES; k++) begin
            v_src[k] = v_q[k-1];
            r_src[k] = r_q[k-1];
            a_src[k] = a_q[k-1];
            b_src[k] = b_q[k-1];
            c_src[k] = c_q[k-1];
        end
    end

    always_comb begin
        slice = '0;
        for (int k = 0; k < STAGES; k++) begin
            slice = {1'b0, a_src[k][k*W +: W]} + {1'b0, b_src[k][k*W +: W]}
                  + {{W{1'b0}}, c_src[k]};
            r_nxt[k]            = r_src[k];
            r_nxt[k][k*W +: W]  = slice[W-1:0];
            c_nxt[k]            = slice[W];
        end
    end

    // One global enable: the whole pipe shifts together or holds together, bubbles included.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                r_q[k] <= '0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= v_src[k];
                r_q[k] <= r_nxt[k];
                a_q[k] <= a_src[k];
                b_q[k] <= b_src[k];
                c_q[k] <= c_nxt[k];
            end
        end
    end

    assign out_valid = v_q[LAST];
    assign sum       = r_q[LAST];
    assign carry_out = c_q[LAST];

`ifdef PIPE_ADD_OVF_EN
    logic ovf_q;

    // The top slice is resolved in the last stage, so overflow is judged there from the operand sign bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= (a_src[LAST][SIZE-1] == b_src[LAST][SIZE-1])
                  && (r_nxt[LAST][SIZE-1] != a_src[LAST][SIZE-1]);
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed vectors, streaming, backpressure, reset and a
// multi-configuration random sweep. Checks ovf as well when PIPE_ADD_OVF_EN is defined.
module tb_pipelined_adder;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] exp_sum;
        logic        exp_cout;
        logic        exp_ovf;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        m_valid, m_iready, m_ovalid, m_ready, m_cin, m_sub, m_cout;
    logic [15:0] m_a, m_b, m_sum;
`ifdef PIPE_ADD_OVF_EN
    logic        m_ovf;
`endif

    logic        sw_valid, sw_cin, sw_sub, sweep_done;
    logic [31:0] sw_a, sw_b;

    int compared;
    int failed;
    int edge_count;

    logic [17:0] exp_q[$];

    pipelined_adder #(.SIZE(16), .STAGES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (m_valid),
        .in_ready  (m_iready),
        .a         (m_a),
        .b         (m_b),
        .cin       (m_cin),
        .sub       (m_sub),
        .out_valid (m_ovalid),
        .out_ready (m_ready),
        .sum       (m_sum),
        .carry_out (m_cout)
`ifdef PIPE_ADD_OVF_EN
        ,
        .ovf       (m_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_count++;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: exact SIZE+1-bit arithmetic and signed range check, returns {ovf, carry_out, sum}.
    function automatic logic [17:0] refModel(input logic [15:0] a, input logic [15:0] b,
                                             input logic cin, input logic sub);
        int ua, ub, sa, sb, r, sr;
        logic o;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            r  = ua - ub - int'(cin) + 65536;
            sr = sa - sb - int'(cin);
        end else begin
            r  = ua + ub + int'(cin);
            sr = sa + sb + int'(cin);
        end
        o = (sr > 32767) || (sr < -32768);
        return {o, r[16], r[15:0]};
    endfunction

    // One isolated transaction: checks acceptance, exact latency of 4 and that no duplicate follows.
    task automatic applyStimulus(input string name, input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub, input logic [15:0] exp_sum,
                                 input logic exp_cout, input logic exp_ovf);
        m_a = a; m_b = b; m_cin = cin; m_sub = sub; m_valid = 1'b1; m_ready = 1'b1;
        #1 checkOutput({name, " in_ready"}, m_iready, 1);
        @(posedge clk); #1 m_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 checkOutput({name, " early"}, m_ovalid, 0);
        @(posedge clk); #1;
        checkOutput({name, " valid"}, m_ovalid, 1);
        checkOutput({name, " sum"}, m_sum, exp_sum);
        checkOutput({name, " carry"}, m_cout, exp_cout);
`ifdef PIPE_ADD_OVF_EN
        checkOutput({name, " ovf"}, m_ovf, exp_ovf);
`else
        if (exp_ovf === 1'bx) $display("[TB] note: unknown ovf expectation in %s", name);
`endif
        @(posedge clk); #1 checkOutput({name, " no dup"}, m_ovalid, 0);
    endtask

    // Streams n_tx transactions against the queue model; random_mode randomises valid/ready/operands,
    // otherwise the scripted pattern drops out_ready for three cycles mid-stream.
    task automatic runStream(input string name, input int n_tx, input bit random_mode, input int budget);
        int          accepted = 0;
        int          cyc = 0;
        bit          held = 0;
        logic [15:0] held_sum = '0;
        logic        held_c = 1'b0;
        logic [17:0] e;
        while ((accepted < n_tx || exp_q.size() > 0) && cyc < budget) begin
            if (held) begin
                checkOutput({name, " hold valid"}, m_ovalid, 1);
                checkOutput({name, " hold sum"}, m_sum, held_sum);
                checkOutput({name, " hold carry"}, m_cout, held_c);
            end
            m_valid = (accepted < n_tx) && (random_mode ? ($urandom_range(0, 9) < 7) : 1'b1);
            if (random_mode) begin
                m_a = 16'($urandom); m_b = 16'($urandom);
                m_cin = 1'($urandom_range(0, 1)); m_sub = 1'($urandom_range(0, 1));
                m_ready = ($urandom_range(0, 9) < 6);
            end else begin
                m_a = 16'(16'h0F00 + accepted * 16'h1234); m_b = 16'(16'h00FF ^ accepted);
                m_cin = 1'(accepted & 1); m_sub = 1'((accepted >> 1) & 1);
                m_ready = !(cyc >= 4 && cyc <= 6);
            end
            #1;
            checkOutput({name, " in_ready rule"}, m_iready, !m_ovalid || m_ready);
            if (m_ovalid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput({name, " unexpected result"}, 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput({name, " sum"}, m_sum, e[15:0]);
                    checkOutput({name, " carry"}, m_cout, e[16]);
`ifdef PIPE_ADD_OVF_EN
                    checkOutput({name, " ovf"}, m_ovf, e[17]);
`endif
                end
            end
            held = m_ovalid && !m_ready;
            held_sum = m_sum;
            held_c = m_cout;
            if (m_valid && m_iready) begin
                exp_q.push_back(refModel(m_a, m_b, m_cin, m_sub));
                accepted++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        m_valid = 1'b0;
        m_ready = 1'b1;
        checkOutput({name, " accepted"}, accepted, n_tx);
        checkOutput({name, " drained"}, exp_q.size(), 0);
        checkOutput({name, " no extra"}, m_ovalid, 0);
        exp_q.delete();
    endtask

    // Configuration sweep: extra instances fed the same random stream, each with its own queue model.
    for (genvar g = 0; g < 5; g++) begin : gen_sweep
        localparam int SZ = (g == 3) ? 8 : (g == 4) ? 32 : 16;
        localparam int ST = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 16 : 4;
        logic [SZ-1:0] s_sum;
        logic          s_cout, s_ovalid, s_iready;
`ifdef PIPE_ADD_OVF_EN
        logic          s_ovf;
`endif
        longint        val_q[$];
        int            edge_q[$];
        longint        ev, ua, ub, r;
        int            ee;

        pipelined_adder #(.SIZE(SZ), .STAGES(ST)) sdut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (sw_valid),
            .in_ready  (s_iready),
            .a         (sw_a[SZ-1:0]),
            .b         (sw_b[SZ-1:0]),
            .cin       (sw_cin),
            .sub       (sw_sub),
            .out_valid (s_ovalid),
            .out_ready (1'b1),
            .sum       (s_sum),
            .carry_out (s_cout)
`ifdef PIPE_ADD_OVF_EN
            ,
            .ovf       (s_ovf)
`endif
        );

        always @(negedge clk) begin
            if (rst) begin
                val_q.delete();
                edge_q.delete();
            end else begin
                if (s_ovalid) begin
                    if (val_q.size() == 0) begin
                        checkOutput($sformatf("sweep%0d unexpected", g), 1, 0);
                    end else begin
                        ev = val_q.pop_front();
                        ee = edge_q.pop_front();
                        checkOutput($sformatf("sweep%0d sum", g), 64'(s_sum), 64'(ev[SZ-1:0]));
                        checkOutput($sformatf("sweep%0d carry", g), s_cout, ev[SZ]);
                        checkOutput($sformatf("sweep%0d latency", g), edge_count, ee + ST - 1);
                    end
                end
                if (sw_valid && s_iready) begin
                    ua = longint'(sw_a[SZ-1:0]);
                    ub = longint'(sw_b[SZ-1:0]);
                    if (sw_sub) r = ua - ub - longint'(sw_cin) + (longint'(1) << SZ);
                    else        r = ua + ub + longint'(sw_cin);
                    val_q.push_back(r);
                    edge_q.push_back(edge_count + 1);
                end
            end
        end

        always @(posedge sweep_done) checkOutput($sformatf("sweep%0d drained", g), val_q.size(), 0);
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[8];
        bit   seen;
        compared = 0; failed = 0; edge_count = 0;
        sweep_done = 1'b0;
        sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0;
        m_valid = 1'b0; m_a = '0; m_b = '0; m_cin = 1'b0; m_sub = 1'b0; m_ready = 1'b0;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0};
        vecs[2] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vecs[5] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[6] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset out_valid", m_ovalid, 0);
        checkOutput("reset sum", m_sum, 0);
        checkOutput("reset carry", m_cout, 0);
        checkOutput("reset in_ready", m_iready, 1);
`ifdef PIPE_ADD_OVF_EN
        checkOutput("reset ovf", m_ovf, 0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++)
            applyStimulus($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                          vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf);

        m_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c < 8) begin
                m_valid = 1'b1; m_a = 16'(c); m_b = 16'(c); m_cin = 1'b0; m_sub = 1'b0;
            end else begin
                m_valid = 1'b0;
            end
            #1 checkOutput("b2b in_ready", m_iready, 1);
            @(posedge clk); #1;
            if (c >= 3 && c <= 10) begin
                checkOutput("b2b valid", m_ovalid, 1);
                checkOutput("b2b sum", m_sum, 2 * (c - 3));
            end else begin
                checkOutput("b2b idle", m_ovalid, 0);
            end
        end

        runStream("backpressure", 6, 1'b0, 100);
        runStream("random", 150, 1'b1, 2000);

        for (int i = 0; i < 5; i++) begin
            m_valid = 1'b1; m_a = 16'(16'h0100 + i); m_b = 16'h0F0F; m_cin = 1'b0; m_sub = 1'b0;
            @(posedge clk); #1;
        end
        m_valid = 1'b0;
        checkOutput("pre-reset valid", m_ovalid, 1);
        checkOutput("pre-reset sum", m_sum, 16'h1010);
        rst = 1'b1;
        m_ready = 1'b0;
        @(posedge clk); #1;
        checkOutput("midreset out_valid", m_ovalid, 0);
        checkOutput("midreset sum", m_sum, 0);
        checkOutput("midreset carry", m_cout, 0);
        checkOutput("midreset in_ready", m_iready, 1);
        rst = 1'b0;
        m_ready = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (m_ovalid) seen = 1'b1;
        end
        checkOutput("no flushed result", seen, 0);
        applyStimulus("post-reset", 16'h00FF, 16'h0F01, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            sw_valid = ($urandom_range(0, 3) != 0);
            sw_a = $urandom; sw_b = $urandom;
            sw_cin = 1'($urandom_range(0, 1)); sw_sub = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        sw_valid = 1'b0;
        repeat (40) @(posedge clk);
        #1 sweep_done = 1'b1;
        #2;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
